// File: rtl/fir_pkg.sv
// Shared definitions for the parametrised FIR filter.
//   - Default widths / tap count used as parameter defaults.
//   - coef_vec_t: packed coefficient vector for the default build, tap 0 in LSBs.
//   - sat_to_out(): clip a sign-extended accumulator to an out_w-bit signed range.
//     It returns {flag, value}. The value is still SAT_W bits wide, and the
//     caller keeps the low out_w bits.
package fir_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_COEF_W = 8;
   localparam int DEF_TAPS   = 4;
   localparam int DEF_OUT_W  = 16;

   // Working width of the saturation helper. Any accumulator up to this width
   // is sign-extended into it before clipping.
   localparam int SAT_W = 64;

   typedef logic [DEF_COEF_W*DEF_TAPS-1:0] coef_vec_t;

   // tap0 = 2, tap1 = 4, tap2 = 8, tap3 = 0
   localparam coef_vec_t DEF_COEF_INIT = {8'd0, 8'd8, 8'd4, 8'd2};

   typedef struct packed {
      logic                    flag;
      logic signed [SAT_W-1:0] value;
   } sat_t;

   function automatic sat_t sat_to_out(input logic signed [SAT_W-1:0] acc,
                                       input int                      out_w);
      sat_t                    res;
      logic signed [SAT_W-1:0] max_pos;
      logic signed [SAT_W-1:0] min_neg;
      max_pos = 64'sd1;
      max_pos = (max_pos <<< (out_w - 1)) - 64'sd1;
      min_neg = -max_pos - 64'sd1;
      if (acc > max_pos) begin
         res.flag  = 1'b1;
         res.value = max_pos;
      end else if (acc < min_neg) begin
         res.flag  = 1'b1;
         res.value = min_neg;
      end else begin
         res.flag  = 1'b0;
         res.value = acc;
      end
      return res;
   endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Sample delay line for the FIR filter.
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset, clears every tap
//   shift_en  advance the line by one sample this cycle
//   din       new sample entering tap 0
//   taps_out  current tap contents, tap k at bits [k*DATA_W +: DATA_W]
module fir_delay_line #(
   parameter int DATA_W = 8,
   parameter int TAPS   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   shift_en,
   input  logic [DATA_W-1:0]      din,
   output logic [TAPS*DATA_W-1:0] taps_out
);

   for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
      logic [DATA_W-1:0] x_reg;
      logic [DATA_W-1:0] x_next;

      if (gi == 0) begin : g_head
         assign x_next = din;
      end else begin : g_body
         assign x_next = taps_out[(gi-1)*DATA_W +: DATA_W];
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            x_reg <= '0;
         end else if (shift_en) begin
            x_reg <= x_next;
         end
      end

      assign taps_out[gi*DATA_W +: DATA_W] = x_reg;
   end

endmodule

// File: rtl/fir_filter_param.sv
// Parametrised N-tap direct-form FIR filter with signed data/coefficients,
// runtime-programmable coefficients and a saturated, valid-qualified output.
// Pipeline: stage 1 registers per-tap products, and stage 2 registers the
// saturated sum. A result appears two cycles after its in_valid.
// Ports:
//   clk, rst            clock / asynchronous active-high reset
//   in_valid, in_data   input sample and its qualifier
//   coef_we, coef_addr,
//   coef_wdata          coefficient write port (out-of-range addresses ignored)
//   out_valid           single-cycle pulse per accepted sample
//   out_data            saturated filter output (holds while out_valid=0)
//   sat_flag            out_data was clipped (holds while out_valid=0)
module fir_filter_param
   import fir_pkg::*;
#(
   parameter int                      DATA_W    = DEF_DATA_W,
   parameter int                      COEF_W    = DEF_COEF_W,
   parameter int                      TAPS      = DEF_TAPS,
   parameter int                      OUT_W     = DEF_OUT_W,
   parameter logic [COEF_W*TAPS-1:0]  COEF_INIT = DEF_COEF_INIT
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   input  logic signed [DATA_W-1:0]    in_data,
   input  logic                        coef_we,
   input  logic [$clog2(TAPS)-1:0]     coef_addr,
   input  logic signed [COEF_W-1:0]    coef_wdata,
   output logic                        out_valid,
   output logic signed [OUT_W-1:0]     out_data,
   output logic                        sat_flag
);

   localparam int ADDR_W = $clog2(TAPS);
   localparam int PROD_W = DATA_W + COEF_W;
   localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);

   logic [TAPS*DATA_W-1:0] taps_flat;
   logic [TAPS*PROD_W-1:0] prod_flat;
   logic                   prod_valid_reg;
   logic signed [ACC_W-1:0] acc_sum;
   logic signed [OUT_W-1:0] out_data_next;
   logic                    sat_flag_next;

   fir_delay_line #(
      .DATA_W (DATA_W),
      .TAPS   (TAPS)
   ) u_delay_line (
      .clk      (clk),
      .rst      (rst),
      .shift_en (in_valid),
      .din      (in_data),
      .taps_out (taps_flat)
   );

   // Per tap: coefficient register plus the stage-1 product register. The
   // product uses the delay line as it will look after this cycle's shift
   // (x'[0] = in_data). It also uses the coefficient before any write at the
   // same edge, so a same-cycle write only affects later samples.
   for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
      logic signed [COEF_W-1:0] coef_reg;
      logic signed [DATA_W-1:0] x_upd;
      logic signed [PROD_W-1:0] prod_reg;

      if (gi == 0) begin : g_head
         assign x_upd = in_data;
      end else begin : g_body
         assign x_upd = $signed(taps_flat[(gi-1)*DATA_W +: DATA_W]);
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            coef_reg <= $signed(COEF_INIT[gi*COEF_W +: COEF_W]);
         end else if (coef_we && (coef_addr == ADDR_W'(gi))) begin
            coef_reg <= coef_wdata;
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            prod_reg <= '0;
         end else if (in_valid) begin
            prod_reg <= PROD_W'(x_upd) * PROD_W'(coef_reg);
         end
      end

      assign prod_flat[gi*PROD_W +: PROD_W] = prod_reg;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod_valid_reg <= 1'b0;
      end else begin
         prod_valid_reg <= in_valid;
      end
   end

   // Stage 2: ACC_W has $clog2(TAPS) guard bits, so the sum cannot overflow.
   always_comb begin
      acc_sum = '0;
      for (int k = 0; k < TAPS; k++) begin
         acc_sum = acc_sum + ACC_W'($signed(prod_flat[k*PROD_W +: PROD_W]));
      end
   end

   always_comb begin : p_sat
      sat_t sat_res;
      sat_res       = sat_to_out(SAT_W'(acc_sum), OUT_W);
      out_data_next = sat_res.value[OUT_W-1:0];
      sat_flag_next = sat_res.flag;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         sat_flag  <= 1'b0;
      end else begin
         out_valid <= prod_valid_reg;
         if (prod_valid_reg) begin
            out_data <= out_data_next;
            sat_flag <= sat_flag_next;
         end
      end
   end

endmodule
